tank_input_decoder: RTL



---
 rtl/tank_input_pkg.sv | 52 +++++
 rtl/fire_ctrl.sv | 56 +++++
 rtl/tank_input_decoder.sv | 99 +++++++++
 3 files changed

// File: rtl/tank_input_pkg.sv
// Shared types and HID key codes for the tank input decoder.
// Per-slot direction lookups are the building blocks of the top-level scan.
package tank_input_pkg;

  typedef enum logic [2:0] {
    DIR_NONE  = 3'd0,
    DIR_UP    = 3'd1,
    DIR_DOWN  = 3'd2,
    DIR_LEFT  = 3'd3,
    DIR_RIGHT = 3'd4
  } dir_t;

  typedef enum logic [1:0] {
    FIRE_READY    = 2'd0,
    FIRE_COOL     = 2'd1,
    FIRE_WAIT_REL = 2'd2
  } fire_state_t;

  localparam logic [7:0] KEY_NONE  = 8'h00;
  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_UP    = 8'h52;
  localparam logic [7:0] KEY_DOWN  = 8'h51;
  localparam logic [7:0] KEY_LEFT  = 8'h50;
  localparam logic [7:0] KEY_RIGHT = 8'h4F;
  localparam logic [7:0] KEY_SPACE = 8'h2C;
  localparam logic [7:0] KEY_ENTER = 8'h28;
  localparam logic [7:0] KEY_R     = 8'h15;

  function automatic dir_t p1_code_dir(input logic [7:0] code);
    case (code)
      KEY_W:   return DIR_UP;
      KEY_S:   return DIR_DOWN;
      KEY_A:   return DIR_LEFT;
      KEY_D:   return DIR_RIGHT;
      default: return DIR_NONE;
    endcase
  endfunction

  function automatic dir_t p2_code_dir(input logic [7:0] code);
    case (code)
      KEY_UP:    return DIR_UP;
      KEY_DOWN:  return DIR_DOWN;
      KEY_LEFT:  return DIR_LEFT;
      KEY_RIGHT: return DIR_RIGHT;
      default:   return DIR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/fire_ctrl.sv
// Per-player fire FSM with an 8-bit frame cooldown; advances only on tick.
// Build option KEY_AUTOFIRE_EN: when defined, a held key re-fires after the cooldown.
module fire_ctrl
  import tank_input_pkg::*;
#(
  parameter logic [7:0] COOLDOWN = 8'd30
) (
  input  logic Clk,
  input  logic Reset,
  input  logic tick,
  input  logic held,
  input  logic game_over,
  output logic fire
);

  fire_state_t state;
  logic [7:0]  count;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= FIRE_READY;
      count <= '0;
      fire  <= 1'b0;
    end else if (tick) begin
      fire <= 1'b0;
      case (state)
        FIRE_READY: begin
          if (held && !game_over) begin
            fire  <= 1'b1;
            count <= COOLDOWN;
            state <= FIRE_COOL;
          end
        end
        FIRE_COOL: begin
          // Leaving on the tick that reaches zero makes the next shot land
          // COOLDOWN+1 frames after the previous one.
          if (count <= 8'd1) begin
            count <= '0;
`ifdef KEY_AUTOFIRE_EN
            state <= FIRE_READY;
`else
            state <= held ? FIRE_WAIT_REL : FIRE_READY;
`endif
          end else begin
            count <= count - 8'd1;
          end
        end
        FIRE_WAIT_REL: begin
          if (!held) state <= FIRE_READY;
        end
        default: state <= FIRE_READY;
      endcase
    end
  end

endmodule

// File: rtl/tank_input_decoder.sv
// Frame-synchronous keycode decoder: per-player direction, fire and restart.
// Build option KEY_AUTOFIRE_EN selects autofire in the fire controllers.
module tank_input_decoder
  import tank_input_pkg::*;
#(
  parameter int         FIRE_COOLDOWN = 30,
  parameter logic [7:0] P1_FIRE_KEY   = KEY_SPACE,
  parameter logic [7:0] P2_FIRE_KEY   = KEY_ENTER,
  parameter logic [7:0] RESTART_KEY   = KEY_R
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_vs,
  input  logic [31:0] keycode,
  input  logic        game_over,
  output dir_t        p1_dir,
  output dir_t        p2_dir,
  output logic        p1_fire,
  output logic        p2_fire,
  output logic        restart,
  output logic        frame_tick
);

  function automatic logic key_held(input logic [31:0] kc, input logic [7:0] code);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (kc[8*i +: 8] == code) hit = 1'b1;
    end
    return hit;
  endfunction

  // Scanning from slot 3 down lets the lowest matching slot overwrite the rest.
  function automatic dir_t scan_dir(input logic [31:0] kc, input logic second);
    dir_t d;
    dir_t s;
    d = DIR_NONE;
    for (int i = 3; i >= 0; i--) begin
      s = second ? p2_code_dir(kc[8*i +: 8]) : p1_code_dir(kc[8*i +: 8]);
      if (s != DIR_NONE) d = s;
    end
    return d;
  endfunction

  logic vs_meta, vs_sync, vs_prev;
  logic restart_prev;
  logic p1_held, p2_held, restart_held;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      vs_meta    <= 1'b0;
      vs_sync    <= 1'b0;
      vs_prev    <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      vs_meta    <= frame_vs;
      vs_sync    <= vs_meta;
      vs_prev    <= vs_sync;
      frame_tick <= vs_sync & ~vs_prev;
    end
  end

  assign p1_held      = key_held(keycode, P1_FIRE_KEY);
  assign p2_held      = key_held(keycode, P2_FIRE_KEY);
  assign restart_held = key_held(keycode, RESTART_KEY);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      p1_dir       <= DIR_NONE;
      p2_dir       <= DIR_NONE;
      restart      <= 1'b0;
      restart_prev <= 1'b0;
    end else if (frame_tick) begin
      p1_dir       <= game_over ? DIR_NONE : scan_dir(keycode, 1'b0);
      p2_dir       <= game_over ? DIR_NONE : scan_dir(keycode, 1'b1);
      restart      <= restart_held & ~restart_prev;
      restart_prev <= restart_held;
    end
  end

  fire_ctrl #(.COOLDOWN(8'(FIRE_COOLDOWN))) u_p1_fire (
    .Clk       (Clk),
    .Reset     (Reset),
    .tick      (frame_tick),
    .held      (p1_held),
    .game_over (game_over),
    .fire      (p1_fire)
  );

  fire_ctrl #(.COOLDOWN(8'(FIRE_COOLDOWN))) u_p2_fire (
    .Clk       (Clk),
    .Reset     (Reset),
    .tick      (frame_tick),
    .held      (p2_held),
    .game_over (game_over),
    .fire      (p2_fire)
  );

endmodule
